// File: rtl/pipe_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit for the EX stage.
// One shift-add or restoring-divide step per cycle, then a one-cycle sign fix.
module pipe_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      busy,
  output logic                      valid,
  output logic [2*DATA_WIDTH-1:0]   result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_is_div;
  logic            r_is_signed;
  logic            r_sign_a;
  logic            r_sign_b;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_opb;
  logic [2*W-1:0]  r_result;
  logic            r_valid;

  logic            w_signed_op;
  logic [W-1:0]    w_abs_a;
  logic [W-1:0]    w_abs_b;
  logic [W:0]      w_mul_sum;
  logic [W:0]      w_div_shift;
  logic [W+1:0]    w_div_trial;
  logic [2*W-1:0]  w_next_acc;
  logic [2*W-1:0]  w_fix_result;

  // Signed ops work on magnitudes; |0x80000000| fits as unsigned 0x80000000.
  assign w_signed_op = ~op[0];
  assign w_abs_a     = (w_signed_op && a[W-1]) ? -a : a;
  assign w_abs_b     = (w_signed_op && b[W-1]) ? -b : b;

  // Multiply: r_acc = {partial product, remaining multiplier bits}, r_opb = multiplicand.
  assign w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_opb : {W{1'b0}})};

  // Divide: r_acc = {partial remainder, dividend/quotient}, r_opb = divisor.
  // The trial is one bit wider than the shifted remainder so a zero divisor never looks negative.
  assign w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_div_trial = {1'b0, w_div_shift} - {2'b00, r_opb};

  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next_acc = r_acc;
    if (r_is_div) begin
      if (!w_div_trial[W+1])
        w_next_acc = {w_div_trial[W-1:0], r_acc[W-2:0], 1'b1};
      else
        w_next_acc = {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0};
    end else begin
      w_next_acc = {w_mul_sum, r_acc[W-1:1]};
    end
  end

  always_comb begin
    w_fix_result = r_acc;
    if (r_is_signed) begin
      if (!r_is_div) begin
        if (r_sign_a ^ r_sign_b)
          w_fix_result = -r_acc;
      end else begin
        // Quotient takes the xor of the signs, remainder takes the sign of the dividend.
        w_fix_result[W-1:0]   = (r_sign_a ^ r_sign_b) ? -r_acc[W-1:0]   : r_acc[W-1:0];
        w_fix_result[2*W-1:W] = r_sign_a              ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
      end
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_is_signed <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_acc       <= '0;
      r_opb       <= '0;
      r_result    <= '0;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_CALC;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_is_div    <= op[1];
            r_is_signed <= w_signed_op;
            r_sign_a    <= w_signed_op & a[W-1];
            r_sign_b    <= w_signed_op & b[W-1];
            if (op[1]) begin
              r_acc <= {{W{1'b0}}, w_abs_a};
              r_opb <= w_abs_b;
            end else begin
              r_acc <= {{W{1'b0}}, w_abs_b};
              r_opb <= w_abs_a;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_next_acc;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_result;
          r_valid  <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign valid  = r_valid;
  assign result = r_result;

endmodule

// File: tb/tb_pipe_muldiv.sv
// Self-checking bench for pipe_muldiv: directed corner cases plus randomized ops,
// compared every cycle against a latency/arithmetic model.
module tb_pipe_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        valid;
  logic [63:0] result;

  int tests = 0;
  int fails = 0;

  int          m_left = 0;
  logic        m_valid = 1'b0;
  logic [63:0] m_result = '0;
  logic [63:0] m_pending = '0;
  logic        noise = 1'b0;

  pipe_muldiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result: plain 64-bit arithmetic with the defined divide-by-zero rules.
  function automatic logic [63:0] ref_fn(input logic [1:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    ua = {32'd0, fa};
    ub = {32'd0, fb};
    res = '0;
    case (f_op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      2'b10: begin
        if (fb == 32'd0) begin
          res[63:32] = fa;
          res[31:0]  = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (fb == 32'd0) res = {fa, 32'hFFFF_FFFF};
        else             res = {fa % fb, fa / fb};
      end
    endcase
    return res;
  endfunction

  // Model: an accepted start makes the unit busy for 33 edges, then the result appears.
  always @(posedge clk) begin
    if (reset) begin
      m_left   <= 0;
      m_valid  <= 1'b0;
      m_result <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left    <= 33;
        m_valid   <= 1'b0;
        m_pending <= ref_fn(op, a, b);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid  <= 1'b1;
        m_result <= m_pending;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("busy",   {63'd0, busy},  {63'd0, (m_left != 0)});
    check("valid",  {63'd0, valid}, {63'd0, m_valid});
    check("result", result, m_result);
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      if (noise && m_left > 0) begin
        start = 1'($urandom);
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end while (!valid && n < 40);
    start = 1'b0;
    check({name, "_latency"}, 64'(n), 64'd33);
  endtask

  task automatic launch(input logic [1:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
    @(negedge clk);
    start = 1'b1;
    op    = f_op;
    a     = fa;
    b     = fb;
    @(posedge clk);
  endtask

  task automatic do_op(input logic [1:0] f_op, input logic [31:0] fa, input logic [31:0] fb,
                       input logic chk, input logic [63:0] exp, input string name);
    launch(f_op, fa, fb);
    wait_done(name);
    if (chk) check(name, result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   {63'd0, busy},  64'd0);
    check("rst_valid",  {63'd0, valid}, 64'd0);
    check("rst_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001, "multu_max");
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "mult_neg");
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "mult_min");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2,         1'b1, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
    do_op(2'b11, 32'd100,       32'd7,         1'b1, 64'h0000_0002_0000_000E, "divu");
    do_op(2'b11, 32'd100,       32'd0,         1'b1, 64'h0000_0064_FFFF_FFFF, "divu_zero");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0,         1'b1, 64'hFFFF_FFF9_0000_0001, "div_zero_neg");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, "div_ovf");

    // A start pulsed while busy must not disturb the running multiply.
    launch(2'b01, 32'd3, 32'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    begin
      int n;
      n = 5;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!valid && n < 40);
      check("ignored_latency", 64'(n), 64'd34);
    end
    check("ignored_start", result, 64'h0000_0000_0000_000F);
    do_op(2'b11, 32'd9, 32'd3, 1'b1, 64'h0000_0000_0000_0003, "b2b_divu");

    // Reset in the middle of a divide aborts it and clears the outputs.
    launch(2'b10, 32'h1234_5678, 32'd77);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy",   {63'd0, busy},  64'd0);
    check("abort_valid",  {63'd0, valid}, 64'd0);
    check("abort_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(2'b01, 32'd2, 32'd2, 1'b1, 64'h0000_0000_0000_0004, "after_reset");

    // Randomized ops, with spurious starts injected while busy on some of them.
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      r_op = 2'($urandom);
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: r_b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      noise = 1'($urandom);
      do_op(r_op, r_a, r_b, 1'b1, ref_fn(r_op, r_a, r_b), "random");
      noise = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
